// File: rtl/seven_segment_clock_div.sv
// -----------------------------------------------------------------------------
// seven_segment_clock_div
// Divides the system clock down to the seven-segment digit-scan rate.
//   HALF    = CLK_FREQ_HZ / (2*OUT_FREQ_HZ), rounded down
//   clk_out = registered, 50% duty, period of 2*HALF enabled clk cycles
// Optional feature macro: SSEG_CLKDIV_TICK_EN
//   Adds the registered 'tick' output, which pulses for one cycle on each
//   0->1 transition of clk_out.
// -----------------------------------------------------------------------------
module seven_segment_clock_div #(
   parameter int CLK_FREQ_HZ = 100000000,
   parameter int OUT_FREQ_HZ = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic clk_out
`ifdef SSEG_CLKDIV_TICK_EN
   ,
   output logic tick
`endif
);

   // A zero output frequency collapses HALF to 0 so the check below fires
   // instead of the elaborator dividing by zero.
   localparam int HALF  = (OUT_FREQ_HZ > 0) ? CLK_FREQ_HZ / (2 * OUT_FREQ_HZ) : 0;
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'((HALF > 0) ? HALF - 1 : 0);

   // Reject configurations that cannot produce a half period of one cycle.
   generate
      if (HALF < 1) begin : g_bad_half
         $error("seven_segment_clock_div: HALF must be >= 1 (CLK_FREQ_HZ=%0d OUT_FREQ_HZ=%0d)",
                CLK_FREQ_HZ, OUT_FREQ_HZ);
      end
   endgenerate

   logic [CNT_W-1:0] r_cnt;
   logic             r_clk_out;
   logic             w_wrap;

   // Terminal count reached on an enabled edge: wrap the counter, toggle clk_out.
   assign w_wrap = en && (r_cnt == LAST);

   // Half-period counter and divided clock; en low freezes both.
   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_clk_out <= 1'b0;
      end else if (en) begin
         if (w_wrap) begin
            r_cnt     <= '0;
            r_clk_out <= ~r_clk_out;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // NOTE: clk_out is driven straight from a flop, never from a decode, so
   // downstream logic clocked by it sees no glitches.
   assign clk_out = r_clk_out;

`ifdef SSEG_CLKDIV_TICK_EN
   logic r_tick;

   // One-cycle strobe aligned with the cycle in which clk_out rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_wrap && !r_clk_out;
      end
   end

   assign tick = r_tick;
`endif

endmodule

// File: tb/tb_seven_segment_clock_div.sv
// -----------------------------------------------------------------------------
// tb_seven_segment_clock_div
// Directed bench for seven_segment_clock_div using three instances:
//   u_h4 : CLK_FREQ_HZ=8, OUT_FREQ_HZ=1 -> HALF=4
//   u_h1 : CLK_FREQ_HZ=2, OUT_FREQ_HZ=1 -> HALF=1 (clk/2)
//   u_h3 : CLK_FREQ_HZ=7, OUT_FREQ_HZ=1 -> HALF=3 (7/2 rounds down)
// All instances share clk, rst_n and en. Expected waveforms are hand-derived
// tables indexed by rising-edge number after reset release.
// With SSEG_CLKDIV_TICK_EN defined the tick output of u_h4 is checked too.
// -----------------------------------------------------------------------------
module tb_seven_segment_clock_div;

   logic clk;
   logic rst_n;
   logic en;
   logic co_h4, co_h1, co_h3;
`ifdef SSEG_CLKDIV_TICK_EN
   logic tk_h4, tk_h1, tk_h3;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   seven_segment_clock_div #(.CLK_FREQ_HZ(8), .OUT_FREQ_HZ(1)) u_h4 (
      .clk(clk), .rst_n(rst_n), .en(en), .clk_out(co_h4)
`ifdef SSEG_CLKDIV_TICK_EN
      , .tick(tk_h4)
`endif
   );

   seven_segment_clock_div #(.CLK_FREQ_HZ(2), .OUT_FREQ_HZ(1)) u_h1 (
      .clk(clk), .rst_n(rst_n), .en(en), .clk_out(co_h1)
`ifdef SSEG_CLKDIV_TICK_EN
      , .tick(tk_h1)
`endif
   );

   seven_segment_clock_div #(.CLK_FREQ_HZ(7), .OUT_FREQ_HZ(1)) u_h3 (
      .clk(clk), .rst_n(rst_n), .en(en), .clk_out(co_h3)
`ifdef SSEG_CLKDIV_TICK_EN
      , .tick(tk_h3)
`endif
   );

   // 10 time-unit system clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: immediate assertion, failures counted and reported.
   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Phase A: 24 edges after first reset release, en low on edges 15..17
   // (u_h4 counter is 2 after edge 14, so its fall moves from edge 16 to 19).
   logic [1:24] en_a   = 24'b11111111111111_000_1111111;
   logic [1:24] exp_h4 = 24'b000111100001_111111000011;
   logic [1:24] exp_h1 = 24'b101010101010_100001010101;
   logic [1:24] exp_h3 = 24'b001110001110_000001110001;
   logic [1:24] exp_t4 = 24'b000100000001_000000000010;

   // Phase B: 4 edges after the mid-period reset, en held high.
   logic [1:4] expb_h4 = 4'b0001;
   logic [1:4] expb_h1 = 4'b1010;
   logic [1:4] expb_h3 = 4'b0011;
   logic [1:4] expb_t4 = 4'b0001;

   // Directed stimulus sequence.
   initial begin
      rst_n = 1'b0;
      en    = 1'b1;

      // Reset held across several edges: everything stays low.
      repeat (3) @(posedge clk);
      #1;
      check("reset_h4", co_h4, 1'b0);
      check("reset_h1", co_h1, 1'b0);
      check("reset_h3", co_h3, 1'b0);
`ifdef SSEG_CLKDIV_TICK_EN
      check("reset_tick_h4", tk_h4, 1'b0);
`endif

      // Release away from the active edge.
      @(negedge clk);
      rst_n = 1'b1;

      // Phase A: free run, enable pause, resume.
      for (int e = 1; e <= 24; e++) begin
         en = en_a[e];
         @(posedge clk);
         #1;
         check($sformatf("phA_h4_e%0d", e), co_h4, exp_h4[e]);
         check($sformatf("phA_h1_e%0d", e), co_h1, exp_h1[e]);
         check($sformatf("phA_h3_e%0d", e), co_h3, exp_h3[e]);
`ifdef SSEG_CLKDIV_TICK_EN
         check($sformatf("phA_tick_h4_e%0d", e), tk_h4, exp_t4[e]);
`endif
      end

      // All three clk_out are high here; reset must clear them without an edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_h4", co_h4, 1'b0);
      check("async_rst_h1", co_h1, 1'b0);
      check("async_rst_h3", co_h3, 1'b0);

      // Still low across an edge while reset is held.
      @(posedge clk);
      #1;
      check("held_rst_h4", co_h4, 1'b0);
      check("held_rst_h1", co_h1, 1'b0);
      check("held_rst_h3", co_h3, 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;

      // Phase B: a full period restarts from zero; u_h4 first rises at edge 4.
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk);
         #1;
         check($sformatf("phB_h4_e%0d", e), co_h4, expb_h4[e]);
         check($sformatf("phB_h1_e%0d", e), co_h1, expb_h1[e]);
         check($sformatf("phB_h3_e%0d", e), co_h3, expb_h3[e]);
`ifdef SSEG_CLKDIV_TICK_EN
         check($sformatf("phB_tick_h4_e%0d", e), tk_h4, expb_t4[e]);
`endif
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/seven_segment_clock_div.md
SEVEN_SEGMENT_CLOCK_DIV -- requirements
Module: seven_segment_clock_div

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100000000, SHALL give the input clock frequency in Hz.
REQ-002 Parameter OUT_FREQ_HZ, default 1000, SHALL give the requested divided-clock frequency in Hz (display scan rate).
REQ-003 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset; reset is asynchronous and active-low.
REQ-005 en  input  1  SHALL be the count enable; high = divider runs, low = divider frozen.
REQ-006 clk_out  output  1  SHALL be the registered divided clock with 50% duty cycle.
REQ-007 tick  output  1  SHALL be a one-cycle strobe, present only when SSEG_CLKDIV_TICK_EN is defined (see Configuration).

Function
REQ-008 HALF SHALL equal CLK_FREQ_HZ / (2*OUT_FREQ_HZ), using integer division that rounds down.
REQ-009 HALF < 1 SHALL be an elaboration-time error.
REQ-010 The internal counter SHALL be max(1, clog2(HALF)) bits wide and SHALL count 0..HALF-1.
REQ-011 On each rising clk edge with en=1 and cnt != HALF-1, cnt SHALL increment by 1.
REQ-012 On each rising clk edge with en=1 and cnt == HALF-1, cnt SHALL wrap to 0 and clk_out SHALL toggle in the same cycle.
REQ-013 On a rising clk edge with en=0, cnt and clk_out SHALL hold their values; en SHALL never clear the count.
REQ-014 The clk_out period SHALL be exactly 2*HALF enabled cycles: high for HALF cycles, then low for HALF cycles.
REQ-015 After reset release with en=1 held high, clk_out SHALL first rise on the HALF-th rising clk edge.
REQ-016 HALF=1 SHALL make clk_out toggle on every enabled edge, giving clk/2.
REQ-017 clk_out SHALL come directly from a flip-flop (no combinational decode) so it is glitch-free.
REQ-018 clk_out SHALL be usable as a clock by downstream digit-scan logic.
REQ-019 tick (when present) SHALL be registered.
REQ-020 tick SHALL be 1 for exactly the one cycle in which clk_out transitions 0->1, and 0 otherwise.
REQ-021 tick SHALL be 0 on any cycle with en=0.

Reset
REQ-022 While rst_n=0, cnt SHALL be 0, clk_out SHALL be 0 and tick SHALL be 0, asynchronously and regardless of clk.
REQ-023 Reset asserted mid-period SHALL force clk_out low immediately.
REQ-024 After reset, the divider SHALL restart a full period from cnt=0; no partial period SHALL be retained.

Configuration
REQ-025 Macro SSEG_CLKDIV_TICK_EN defined: the tick port and its register SHALL exist and behave per REQ-019 to REQ-021.
REQ-026 Macro SSEG_CLKDIV_TICK_EN undefined: the tick port SHALL be absent; clk_out behaviour SHALL be identical to the defined case.

Verification
REQ-027 Defaults, en=1 after reset release -> clk_out rises at edge 50000 and falls at edge 100000; period is 100000 cycles.
REQ-028 CLK_FREQ_HZ=8, OUT_FREQ_HZ=1 (HALF=4), en=1 -> clk_out sequence per edge is 0,0,0,1,1,1,1,0,0,0,0,1...
REQ-029 HALF=4, en dropped for 3 cycles while cnt=2 -> the next clk_out transition is delayed by exactly 3 cycles and the duty is otherwise unchanged.
REQ-030 HALF=4, rst_n pulsed low while clk_out=1 -> clk_out=0 without waiting for a clk edge; after release, the first rise is at edge 4.
REQ-031 CLK_FREQ_HZ=2, OUT_FREQ_HZ=1 (HALF=1) -> clk_out toggles on every edge.
REQ-032 SSEG_CLKDIV_TICK_EN defined, HALF=4 -> tick is high only at edges 4, 12, 20, ..., and there are zero tick pulses while en=0.
